// File: rtl/dir_tx.sv
// ============================================================================
// Module   : dir_tx
// Purpose  : UART 8N1 transmitter that sends this board's snake direction and
//            game result to the remote board. Direction updates coalesce
//            (latest wins); a result byte takes priority and ends the game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] dir,
  input  logic       won,
  input  logic       lost,
  input  logic       draw,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // One cycle before the last stop-bit cycle: sent is registered, so it is
  // armed here to appear exactly on the final cycle.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             sent_q;

  logic [7:0]       dir_byte_q;
  logic [7:0]       res_byte_q;
  logic             dir_pend_q;
  logic             res_pend_q;
  logic             over_q;

  logic             launch;

  // A frame leaves IDLE whenever anything is pending.
  assign launch = (state_q == IDLE) && (res_pend_q || dir_pend_q);

  // Pending-byte bookkeeping: launch clears the byte being sent, and a tick in
  // the same cycle re-arms the slot with the new byte (no loss, no merge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_byte_q <= 8'h00;
      res_byte_q <= 8'h00;
      dir_pend_q <= 1'b0;
      res_pend_q <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      if (launch) begin
        if (res_pend_q) res_pend_q <= 1'b0;
        else            dir_pend_q <= 1'b0;
      end
      if (tick && !over_q) begin
        if (won || lost || draw) begin
          res_byte_q <= {4'b0101, 1'b0, won, lost, draw};
          res_pend_q <= 1'b1;
          dir_pend_q <= 1'b0;
          over_q     <= 1'b1;
        end else begin
          dir_byte_q <= {4'b1010, 1'b0, dir};
          dir_pend_q <= 1'b1;
        end
      end
    end
  end

  // Serialiser FSM; tx/busy/sent are registered alongside the state so they
  // always match the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (launch) begin
            shift_q <= res_pend_q ? res_byte_q : dir_byte_q;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_PRE) sent_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign sent = sent_q;

endmodule

`default_nettype wire
